// File: rtl/mux_unstriping_if.sv
// Lane inputs and recombined output of the two-lane unstriping stage.
// The master drives the lanes and the slave drives the output stream.
interface mux_unstriping_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data_in0;
    logic             valid_in0;
    logic [WIDTH-1:0] data_in1;
    logic             valid_in1;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             lane_sel;
    logic             error;

    modport master (
        output data_in0, valid_in0, data_in1, valid_in1,
        input  data_out, valid_out, lane_sel, error
    );

    modport slave (
        input  data_in0, valid_in0, data_in1, valid_in1,
        output data_out, valid_out, lane_sel, error
    );
endinterface

// File: rtl/mux_unstriping.sv
// Recombines two striped lanes into one word stream, strictly alternating lane 0 / lane 1.
// Optional macro UNSTRIPE_SKEW_BUF_EN deepens each lane buffer from 1 to 2 words.
module mux_unstriping #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_L,
    mux_unstriping_if.slave  bus
);

`ifdef UNSTRIPE_SKEW_BUF_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    // Storage is always two entries deep so a 1-bit pointer indexes it; CAP limits occupancy.
    logic [WIDTH-1:0] r_mem     [2][2];
    logic             r_rd_ptr  [2];
    logic             r_wr_ptr  [2];
    logic [1:0]       r_count   [2];
    logic [WIDTH-1:0] r_data_out;
    logic             r_valid_out;
    logic             r_lane_sel;
    logic             r_error;

    logic [WIDTH-1:0] w_in_data  [2];
    logic             w_in_valid [2];
    logic             w_pop;
    logic             w_pop_lane [2];
    logic             w_push     [2];
    logic             w_drop     [2];

    function automatic logic ptr_next(input logic p);
        return (CAP == 1) ? 1'b0 : ~p;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch can form.
        w_in_data[0]  = bus.data_in0;
        w_in_data[1]  = bus.data_in1;
        w_in_valid[0] = bus.valid_in0;
        w_in_valid[1] = bus.valid_in1;
        w_pop         = (r_count[r_lane_sel] != 2'd0);
        for (int l = 0; l < 2; l++) begin
            w_pop_lane[l] = w_pop && (r_lane_sel == 1'(l));
            w_push[l]     = w_in_valid[l] && ((r_count[l] != 2'(CAP)) || w_pop_lane[l]);
            w_drop[l]     = w_in_valid[l] && (r_count[l] == 2'(CAP)) && !w_pop_lane[l];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            for (int l = 0; l < 2; l++) begin
                r_rd_ptr[l] <= 1'b0;
                r_wr_ptr[l] <= 1'b0;
                r_count[l]  <= 2'd0;
            end
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
            r_lane_sel  <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (w_push[l])
                    r_wr_ptr[l] <= ptr_next(r_wr_ptr[l]);
                if (w_pop_lane[l])
                    r_rd_ptr[l] <= ptr_next(r_rd_ptr[l]);
                r_count[l] <= r_count[l] + {1'b0, w_push[l]} - {1'b0, w_pop_lane[l]};
            end
            if (w_pop) begin
                r_data_out <= r_mem[r_lane_sel][r_rd_ptr[r_lane_sel]];
                r_lane_sel <= ~r_lane_sel;
            end
            r_valid_out <= w_pop;
            if (w_drop[0] || w_drop[1])
                r_error <= 1'b1;
        end
    end

    // NOTE: the word storage has no reset; emptying a lane only needs its count and pointers cleared.
    always_ff @(posedge clk) begin
        for (int l = 0; l < 2; l++) begin
            if (reset_L && w_push[l])
                r_mem[l][r_wr_ptr[l]] <= w_in_data[l];
        end
    end

    assign bus.data_out  = r_data_out;
    assign bus.valid_out = r_valid_out;
    assign bus.lane_sel  = r_lane_sel;
    assign bus.error     = r_error;

endmodule

// File: tb/tb_mux_unstriping.sv
// Directed bench for mux_unstriping; honours UNSTRIPE_SKEW_BUF_EN when it is defined.
module tb_mux_unstriping;

    logic clk = 1'b0;
    logic reset_L;
    int   n_checks = 0;
    int   n_errors = 0;

    mux_unstriping_if #(.WIDTH(32)) bus ();

    mux_unstriping #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
        bus.valid_in0 = v0;
        bus.data_in0  = d0;
        bus.valid_in1 = v1;
        bus.data_in1  = d1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] exp);
        check({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd1);
        check({tag, "_data"}, bus.data_out, exp);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, {31'd0, bus.valid_out}, 32'd0);
    endtask

    initial begin
        // Reset held two edges with both lanes asserting valid.
        reset_L = 1'b0;
        drive(1'b1, 32'hDEAD0000, 1'b1, 32'hDEAD0001);
        step();
        step();
        check("rst_data",  bus.data_out, 32'd0);
        check("rst_valid", {31'd0, bus.valid_out}, 32'd0);
        check("rst_lane",  {31'd0, bus.lane_sel}, 32'd0);
        check("rst_error", {31'd0, bus.error}, 32'd0);
        reset_L = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_idle("post_rst0");
        step();
        check_idle("post_rst1");

        // Balanced stream; the single-entry build needs one idle edge between pairs.
        drive(1'b1, 32'hA0000000, 1'b1, 32'hA0000001);
        step();
        check_idle("bal_latency");
`ifdef UNSTRIPE_SKEW_BUF_EN
        drive(1'b1, 32'hA0000002, 1'b1, 32'hA0000003);
`else
        drive(1'b0, 32'd0, 1'b0, 32'd0);
`endif
        step();
        check_word("bal_w0", 32'hA0000000);
`ifdef UNSTRIPE_SKEW_BUF_EN
        drive(1'b0, 32'd0, 1'b0, 32'd0);
`else
        drive(1'b1, 32'hA0000002, 1'b1, 32'hA0000003);
`endif
        step();
        check_word("bal_w1", 32'hA0000001);
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_word("bal_w2", 32'hA0000002);
        step();
        check_word("bal_w3", 32'hA0000003);
        check("bal_error", {31'd0, bus.error}, 32'd0);
        check("bal_lane",  {31'd0, bus.lane_sel}, 32'd0);
        step();
        check_idle("bal_drained");

        // Lane 1 arrives one edge ahead of lane 0.
        drive(1'b0, 32'd0, 1'b1, 32'h11111111);
        step();
        check_idle("skew_wait0");
        drive(1'b1, 32'h00000000, 1'b0, 32'd0);
        step();
        check_idle("skew_wait1");
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_word("skew_w0", 32'h00000000);
        check("skew_lane1", {31'd0, bus.lane_sel}, 32'd1);
        step();
        check_word("skew_w1", 32'h11111111);
        check("skew_lane0", {31'd0, bus.lane_sel}, 32'd0);

        // Lane 1 overflows while lane 0 is idle.
        drive(1'b0, 32'd0, 1'b1, 32'd1);
        step();
        check("ovf_err_first", {31'd0, bus.error}, 32'd0);
        drive(1'b0, 32'd0, 1'b1, 32'd2);
        step();
`ifndef UNSTRIPE_SKEW_BUF_EN
        check("ovf_err_second", {31'd0, bus.error}, 32'd1);
`endif
        drive(1'b0, 32'd0, 1'b1, 32'd3);
        step();
        check("ovf_err_third", {31'd0, bus.error}, 32'd1);
        check_idle("ovf_stall");
        drive(1'b1, 32'd9, 1'b0, 32'd0);
        step();
        check_idle("ovf_lat");
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_word("ovf_w9", 32'd9);
        step();
        check_word("ovf_w1", 32'd1);
        check("ovf_sticky", {31'd0, bus.error}, 32'd1);

        // Reset with words buffered.
        drive(1'b1, 32'h55, 1'b1, 32'h66);
        step();
        reset_L = 1'b0;
        drive(1'b1, 32'h77, 1'b1, 32'h78);
        step();
        check("mrst_valid", {31'd0, bus.valid_out}, 32'd0);
        check("mrst_lane",  {31'd0, bus.lane_sel}, 32'd0);
        check("mrst_error", {31'd0, bus.error}, 32'd0);
        check("mrst_data",  bus.data_out, 32'd0);
        reset_L = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_idle("mrst_stale0");
        step();
        check_idle("mrst_stale1");
        drive(1'b1, 32'h12345678, 1'b1, 32'h9ABCDEF0);
        step();
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_word("mrst_w0", 32'h12345678);
        step();
        check_word("mrst_w1", 32'h9ABCDEF0);

`ifdef UNSTRIPE_SKEW_BUF_EN
        // Lane 0 full when a push coincides with a pop from lane 0.
        drive(1'b1, 32'd10, 1'b0, 32'd0);
        step();
        drive(1'b1, 32'd11, 1'b0, 32'd0);
        step();
        check_word("fwp_x0", 32'd10);
        drive(1'b1, 32'd12, 1'b0, 32'd0);
        step();
        check_idle("fwp_fill");
        drive(1'b0, 32'd0, 1'b1, 32'd20);
        step();
        check_idle("fwp_y0_lat");
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_word("fwp_y0", 32'd20);
        drive(1'b1, 32'd13, 1'b1, 32'd21);
        step();
        check_word("fwp_x1", 32'd11);
        check("fwp_no_err", {31'd0, bus.error}, 32'd0);
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_word("fwp_y1", 32'd21);
        step();
        check_word("fwp_x2", 32'd12);
        drive(1'b0, 32'd0, 1'b1, 32'd22);
        step();
        check_idle("fwp_y2_lat");
        drive(1'b0, 32'd0, 1'b0, 32'd0);
        step();
        check_word("fwp_y2", 32'd22);
        step();
        check_word("fwp_x3", 32'd13);
        check("fwp_err_end", {31'd0, bus.error}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
